parity_frame_checker: RTL and testbench

//  Receive end of the 5-bit XOR parity scheme: deserialises framed words
//  (start, DATA_W data bits LSB-first, even-parity bit, stop), recomputes the
//  XOR over data+parity and reports parity and framing errors. The decoded word
//  is presented on a one-entry valid/ready output buffer to downstream logic.
//  The default DATA_W=4 gives the 5-bit (4 data + 1 parity) XOR check.

---
 rtl/pfc_pkg.sv | 17 +
 rtl/pfc_out_buf.sv | 66 ++++++
 rtl/parity_frame_checker.sv | 127 ++++++++++++
 tb/tb_parity_frame_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pfc_pkg.sv
// Shared definitions for the parity frame checker: receiver state encoding
// and the line levels that delimit a frame.
package pfc_pkg;

  // Receiver states: wait for start, collect data, take parity, take stop.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } pfc_state_t;

  // Idle line is high; a low bit opens a frame and a high bit must close it.
  localparam logic PFC_START_BIT = 1'b0;
  localparam logic PFC_STOP_BIT  = 1'b1;

endpackage

// File: rtl/pfc_out_buf.sv
// One-entry valid/ready holding buffer for decoded words and their error
// flags. A word completing while the buffer is full and not being drained
// is dropped, and a single-cycle overrun pulse reports the loss.
module pfc_out_buf
  import pfc_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_par_err,
  input  logic              i_frm_err,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_par_err,
  output logic              o_frm_err,
  output logic              o_overrun
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_par_err;
  logic              r_frm_err;
  logic              r_overrun;

  logic              w_drain;
  logic              w_accept;

  // The held word leaves on a handshake; a new word may take its slot in the
  // same cycle, so back-to-back frames never stall a ready consumer.
  assign w_drain  = r_valid && i_ready;
  assign w_accept = i_load && (!r_valid || w_drain);

  // Buffer state: load on accept, empty on drain, flag frames that found no room.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of its neighbours, independent of statement order.
      r_overrun <= i_load && !w_accept;
      if (w_accept) begin
        r_valid   <= 1'b1;
        r_data    <= i_data;
        r_par_err <= i_par_err;
        r_frm_err <= i_frm_err;
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_par_err = r_par_err;
  assign o_frm_err = r_frm_err;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/parity_frame_checker.sv
// Receive side of the XOR parity link: deserialises start / DATA_W data bits
// (LSB first) / even parity / stop frames, checks parity and framing, and
// hands each word with its error flags to a one-entry output buffer.
// Build option: define PFC_ERR_CNT_EN to add the saturating err_cnt output.
module parity_frame_checker
  import pfc_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_vld,
  input  logic              bit_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              par_err,
  output logic              frm_err,
  output logic              overrun,
  output logic              busy
`ifdef PFC_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_cnt
`endif
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  // Parameter ranges the design is meant for; nothing is built here.
  if (DATA_W < 1 || DATA_W > 16 || CNT_W < 1) begin : g_cfg_out_of_range
  end

  pfc_state_t        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [IDX_W-1:0]  r_idx;
  logic              r_acc;
  logic              r_busy;

  logic              w_frame_done;
  logic              w_frm_err;

  // A frame completes on the qualified stop-bit sample; by then r_acc holds
  // the XOR of all data bits and the parity bit.
  assign w_frame_done = bit_vld && (r_state == STOP);
  assign w_frm_err    = (bit_in != PFC_STOP_BIT);

  // Deserialiser FSM; every register holds on cycles without bit_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= '0;
      r_acc   <= 1'b0;
      r_busy  <= 1'b0;
    end else if (bit_vld) begin
      case (r_state)
        IDLE: begin
          if (bit_in == PFC_START_BIT) begin
            r_state <= DATA;
            r_idx   <= '0;
            r_acc   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        DATA: begin
          r_shift[r_idx] <= bit_in;
          r_acc          <= r_acc ^ bit_in;
          if (r_idx == LAST_IDX) begin
            r_state <= PARITY;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        PARITY: begin
          r_acc   <= r_acc ^ bit_in;
          r_state <= STOP;
        end
        STOP: begin
          // Back to IDLE so a start bit on the very next sample is caught.
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;

  pfc_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_frame_done),
    .i_data    (r_shift),
    .i_par_err (r_acc),
    .i_frm_err (w_frm_err),
    .i_ready   (out_ready),
    .o_valid   (out_valid),
    .o_data    (out_data),
    .o_par_err (par_err),
    .o_frm_err (frm_err),
    .o_overrun (overrun)
  );

`ifdef PFC_ERR_CNT_EN
  logic [CNT_W-1:0] r_err_cnt;

  // Count every errored frame, including ones the buffer had to drop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_frame_done && (r_acc || w_frm_err) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + CNT_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker. A frame-level model (bit queue
// per frame, one-slot buffer) predicts the outputs every cycle; hand-computed
// literals pin the model on the key scenarios.
module tb_parity_frame_checker;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              par;
    logic              frm;
  } word_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              bit_vld = 1'b0;
  logic              bit_in = 1'b1;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              par_err;
  logic              frm_err;
  logic              overrun;
  logic              busy;
`ifdef PFC_ERR_CNT_EN
  logic [CNT_W-1:0]  err_cnt;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  parity_frame_checker #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_vld   (bit_vld),
    .bit_in    (bit_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .par_err   (par_err),
    .frm_err   (frm_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef PFC_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  bit    started = 1'b0;
  bit    m_collect = 1'b0;
  bit    m_q[$];
  bit    m_valid = 1'b0;
  word_t m_word = '0;
  bit    m_overrun = 1'b0;
  int    m_cnt = 0;
  word_t dut_log[$];

  initial forever begin : model
    word_t w;
    bit    fin;
    bit    drain;
    bit    x;
    @(posedge clk);
    started = 1'b1;
    if (rst) begin
      m_q.delete();
      m_collect = 1'b0;
      m_valid   = 1'b0;
      m_word    = '0;
      m_overrun = 1'b0;
      m_cnt     = 0;
    end else begin
      drain = m_valid && out_ready;
      fin   = 1'b0;
      w     = '0;
      if (bit_vld) begin
        if (!m_collect) begin
          if (bit_in == 1'b0) begin
            m_collect = 1'b1;
            m_q.delete();
          end
        end else begin
          m_q.push_back(bit_in);
          if (m_q.size() == DATA_W + 2) begin
            fin       = 1'b1;
            m_collect = 1'b0;
            x         = 1'b0;
            for (int i = 0; i < DATA_W; i++) w.data[i] = m_q[i];
            for (int i = 0; i <= DATA_W; i++) x = x ^ m_q[i];
            w.par = x;
            w.frm = !m_q[DATA_W + 1];
          end
        end
      end
      m_overrun = 1'b0;
      if (fin && (!m_valid || drain)) begin
        m_valid = 1'b1;
        m_word  = w;
      end else begin
        if (fin) m_overrun = 1'b1;
        if (drain) m_valid = 1'b0;
      end
      if (fin && (w.par || w.frm) && m_cnt < (1 << CNT_W) - 1) m_cnt++;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin : compare
    @(negedge clk);
    if (started) begin
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_collect));
      check("overrun", 32'(overrun), 32'(m_overrun));
      if (m_valid) begin
        check("out_data", 32'(out_data), 32'(m_word.data));
        check("par_err", 32'(par_err), 32'(m_word.par));
        check("frm_err", 32'(frm_err), 32'(m_word.frm));
      end
`ifdef PFC_ERR_CNT_EN
      check("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
      if (out_valid && out_ready && !rst) dut_log.push_back(word_t'({out_data, par_err, frm_err}));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic v, input logic b);
    bit_vld = v;
    bit_in  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b1);
  endtask

  // Sends start, data LSB first, parity, stop; returns #1 after the stop sample.
  // With gap set, a non-qualified cycle carrying a misleading level precedes each bit.
  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s, input bit gap);
    logic [DATA_W+2:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < DATA_W + 3; i++) begin
      if (gap) cyc(1'b0, !f[i]);
      cyc(1'b1, f[i]);
    end
  endtask

  task automatic log_expect(input string name, input int n, input word_t first);
    check({name, " count"}, 32'(dut_log.size()), 32'(n));
    if (dut_log.size() > 0) check({name, " word"}, 32'(dut_log[0]), 32'(first));
    dut_log.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int n_bulk;
    logic [DATA_W-1:0] d;

    rst = 1'b1;
    idle(2);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset flags", 32'({par_err, frm_err, overrun}), 32'd0);
`ifdef PFC_ERR_CNT_EN
    check("reset err_cnt", 32'(err_cnt), 32'd0);
`endif
    rst = 1'b0;
    idle(2);

    // 1: good frame 4'hD, parity 1
    out_ready = 1'b1;
    send_frame(4'hD, 1'b1, 1'b1, 1'b0);
    check("t1 out_valid", 32'(out_valid), 32'd1);
    check("t1 out_data", 32'(out_data), 32'hD);
    check("t1 par/frm", 32'({par_err, frm_err}), 32'd0);
    idle(3);
    log_expect("t1", 1, word_t'({4'hD, 1'b0, 1'b0}));

    // 2: same data, wrong parity
    send_frame(4'hD, 1'b0, 1'b1, 1'b0);
    check("t2 out_data", 32'(out_data), 32'hD);
    check("t2 par_err", 32'(par_err), 32'd1);
    check("t2 frm_err", 32'(frm_err), 32'd0);
`ifdef PFC_ERR_CNT_EN
    check("t2 err_cnt", 32'(err_cnt), 32'd1);
`endif
    idle(3);
    log_expect("t2", 1, word_t'({4'hD, 1'b1, 1'b0}));

    // 3: data 0, parity 0, stop 0 -> framing error only
    send_frame(4'h0, 1'b0, 1'b0, 1'b0);
    check("t3 par/frm", 32'({par_err, frm_err}), 32'b01);
`ifdef PFC_ERR_CNT_EN
    check("t3 err_cnt", 32'(err_cnt), 32'd2);
`endif
    idle(3);
    log_expect("t3", 1, word_t'({4'h0, 1'b0, 1'b1}));

    // 4: buffer full, second frame dropped with a one-cycle overrun
    out_ready = 1'b0;
    send_frame(4'h3, 1'b0, 1'b1, 1'b0);
    check("t4 first out_data", 32'(out_data), 32'h3);
    idle(2);
    send_frame(4'h5, 1'b0, 1'b1, 1'b0);
    check("t4 overrun pulse", 32'(overrun), 32'd1);
    check("t4 held out_data", 32'(out_data), 32'h3);
    check("t4 still valid", 32'(out_valid), 32'd1);
    idle(1);
    check("t4 overrun end", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    idle(1);
    check("t4 drained", 32'(out_valid), 32'd0);
    idle(2);
    log_expect("t4", 1, word_t'({4'h3, 1'b0, 1'b0}));

    // 5: bit_vld every other cycle, frame 4'hA
    send_frame(4'hA, 1'b0, 1'b1, 1'b1);
    check("t5 latency out_valid", 32'(out_valid), 32'd1);
    check("t5 out_data", 32'(out_data), 32'hA);
    check("t5 busy", 32'(busy), 32'd0);
    idle(3);
    log_expect("t5", 1, word_t'({4'hA, 1'b0, 1'b0}));

    // 6: reset mid-frame, then a clean frame 4'h6
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    check("t6 busy mid", 32'(busy), 32'd1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("t6 busy after rst", 32'(busy), 32'd0);
`ifdef PFC_ERR_CNT_EN
    check("t6 err_cnt after rst", 32'(err_cnt), 32'd0);
`endif
    send_frame(4'h6, 1'b0, 1'b1, 1'b0);
    idle(3);
    log_expect("t6", 1, word_t'({4'h6, 1'b0, 1'b0}));

    // 7: back-to-back parity-errored frames (counter saturation when enabled)
`ifdef PFC_ERR_CNT_EN
    n_bulk = 300;
`else
    n_bulk = 20;
`endif
    for (int i = 0; i < n_bulk; i++) begin
      d = DATA_W'(i);
      send_frame(d, ~(^d), 1'b1, 1'b0);
    end
    idle(3);
    check("t7 words delivered", 32'(dut_log.size()), 32'(n_bulk));
    dut_log.delete();
`ifdef PFC_ERR_CNT_EN
    check("t7 err_cnt saturated", 32'(err_cnt), 32'hFF);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
